// File: rtl/fft_pkg.sv
// Shared types and address helpers for the radix-2 FFT sequencer.
package fft_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, UNLOAD} state_t;

    // Rotate the low n2 bits of value left by amount.
    function automatic logic [31:0] rotl(input logic [31:0] value, input int amount, input int n2);
        logic [31:0] w_mask;
        w_mask = (32'd1 << n2) - 32'd1;
        return (((value & w_mask) << amount) | ((value & w_mask) >> (n2 - amount))) & w_mask;
    endfunction

    // Top 'level' bits of an (n2-1)-bit field; level 0 gives 0.
    function automatic logic [31:0] twiddle_mask(input int level, input int n2);
        return ((32'd1 << level) - 32'd1) << (n2 - 1 - level);
    endfunction

    function automatic logic [31:0] bitrev(input logic [31:0] value, input int n2);
        logic [31:0] r;
        r = '0;
        for (int b = 0; b < 32; b++)
            if (b < n2) r[b] = value[n2 - 1 - b];
        return r;
    endfunction

endpackage

// File: rtl/fft_ctrl_adrgen.sv
// Butterfly address generator: (level, fly) -> operand pair addresses and twiddle index.
// Purely combinational; the caller registers the addresses for the execute stage.
module fft_ctrl_adrgen
    import fft_pkg::*;
#(
    parameter int N_2 = 5
) (
    input  logic [N_2-1:0] i_level,
    input  logic [N_2-2:0] i_fly,
    output logic [N_2-1:0] o_adra,
    output logic [N_2-1:0] o_adrb,
    output logic [N_2-2:0] o_twiddleadr
);
    localparam int TW = N_2 - 1;

    logic [31:0] w_base;
    logic [31:0] w_mask;

    assign w_base       = {{(32-N_2){1'b0}}, i_fly, 1'b0};
    assign w_mask       = twiddle_mask(int'(i_level), N_2);
    assign o_adra       = N_2'(rotl(w_base, int'(i_level), N_2));
    assign o_adrb       = N_2'(rotl(w_base | 32'd1, int'(i_level), N_2));
    assign o_twiddleadr = TW'(w_mask) & i_fly;

endmodule

// File: rtl/fft_ctrl.sv
// Sequencer for the in-place radix-2 FFT: bit-reversed LOAD, ping-pong COMPUTE, natural-order UNLOAD.
// Owns all RAM addresses, write enables, bank select and twiddle address.
module fft_ctrl
    import fft_pkg::*;
#(
    parameter int N_2 = 5
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           start,
    output logic           busy,
    output logic           done,
    input  logic           sample_valid,
    output logic           sample_ready,
    output logic           load_mode,
    output logic           we0,
    output logic [N_2-1:0] adr0a,
    output logic [N_2-1:0] adr0b,
    output logic           we1,
    output logic [N_2-1:0] adr1a,
    output logic [N_2-1:0] adr1b,
    output logic           rdsel,
    output logic [N_2-2:0] twiddleadr,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           out_last
);
    localparam int             N           = 1 << N_2;
    localparam logic [N_2-1:0] IDX_LAST    = N_2'(N - 1);
    localparam logic [N_2-1:0] FLY_FLUSH   = N_2'(N / 2);
    localparam logic [N_2-1:0] LEVEL_LAST  = N_2'(N_2 - 1);
    localparam logic           RDSEL_FINAL = 1'(N_2 % 2);

    state_t         r_state;
    logic [N_2-1:0] r_idx;
    logic [N_2-1:0] r_level;
    logic [N_2-1:0] r_fly;
    logic           r_ex_vld;
    logic [N_2-1:0] r_ex_adra;
    logic [N_2-1:0] r_ex_adrb;

    logic [N_2-1:0] w_adra;
    logic [N_2-1:0] w_adrb;
    logic [N_2-2:0] w_twiddleadr;
    logic [N_2-1:0] w_bitrev;

    fft_ctrl_adrgen #(.N_2(N_2)) u_adrgen (
        .i_level      (r_level),
        .i_fly        (r_fly[N_2-2:0]),
        .o_adra       (w_adra),
        .o_adrb       (w_adrb),
        .o_twiddleadr (w_twiddleadr)
    );

    assign w_bitrev = N_2'(bitrev({{(32-N_2){1'b0}}, r_idx}, N_2));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_level   <= '0;
            r_fly     <= '0;
            r_ex_vld  <= 1'b0;
            r_ex_adra <= '0;
            r_ex_adrb <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= LOAD;
                        r_idx   <= '0;
                    end
                end
                LOAD: begin
                    if (sample_valid) begin
                        r_idx <= r_idx + 1'b1;
                        if (r_idx == IDX_LAST) begin
                            r_state  <= COMPUTE;
                            r_level  <= '0;
                            r_fly    <= '0;
                            r_ex_vld <= 1'b0;
                        end
                    end
                end
                COMPUTE: begin
                    // Fly count N/2 is the flush slot: it only retires the last issued fly.
                    r_ex_vld  <= (r_fly != FLY_FLUSH);
                    r_ex_adra <= w_adra;
                    r_ex_adrb <= w_adrb;
                    if (r_fly == FLY_FLUSH) begin
                        r_fly <= '0;
                        if (r_level == LEVEL_LAST) begin
                            r_state <= UNLOAD;
                            r_idx   <= '0;
                        end else begin
                            r_level <= r_level + 1'b1;
                        end
                    end else begin
                        r_fly <= r_fly + 1'b1;
                    end
                end
                UNLOAD: begin
                    if (out_ready) begin
                        r_idx <= r_idx + 1'b1;
                        if (r_idx == IDX_LAST) r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        busy         = (r_state != IDLE);
        done         = 1'b0;
        sample_ready = 1'b0;
        load_mode    = 1'b0;
        we0          = 1'b0;
        adr0a        = '0;
        adr0b        = '0;
        we1          = 1'b0;
        adr1a        = '0;
        adr1b        = '0;
        rdsel        = 1'b0;
        twiddleadr   = '0;
        out_valid    = 1'b0;
        out_last     = 1'b0;
        case (r_state)
            LOAD: begin
                sample_ready = 1'b1;
                load_mode    = 1'b1;
                we0          = sample_valid;
                adr0a        = w_bitrev;
                adr0b        = w_bitrev ^ N_2'(1);
            end
            COMPUTE: begin
                adr0a      = r_ex_adra;
                adr0b      = r_ex_adrb;
                adr1a      = r_ex_adra;
                adr1b      = r_ex_adrb;
                rdsel      = r_level[0];
                // Results land in the bank not being read this level.
                we0        = r_ex_vld & r_level[0];
                we1        = r_ex_vld & ~r_level[0];
                twiddleadr = (r_fly != FLY_FLUSH) ? w_twiddleadr : '0;
            end
            UNLOAD: begin
                rdsel     = RDSEL_FINAL;
                adr0a     = r_idx;
                adr1a     = r_idx;
                out_valid = 1'b1;
                out_last  = (r_idx == IDX_LAST);
                done      = out_ready & (r_idx == IDX_LAST);
            end
            default: ;
        endcase
    end

endmodule
